// File: rtl/lifo_pkg.sv
// rtl/lifo_pkg.sv - shared constants and helpers for the lifo_ext stack
//
// Contents:
//   LIFO_DEFAULT_*     default parameter values for lifo_ext
//   lifo_count_width() width of a counter able to hold 0..depth inclusive
package lifo_pkg;

  localparam int LIFO_DEFAULT_DEPTH      = 12;
  localparam int LIFO_DEFAULT_DATA_WIDTH = 8;
  localparam int LIFO_DEFAULT_AF_MARGIN  = 2;
  localparam int LIFO_DEFAULT_AE_MARGIN  = 2;

  // The occupancy counter must represent DEPTH itself (full), hence depth+1.
  function automatic int lifo_count_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/lifo_mem.sv
// rtl/lifo_mem.sv - DEPTH x DATA_WIDTH register file, 1 sync write, 2 async reads
//
// Ports:
//   clk        write clock
//   wr_en      write strobe; wr_data is stored at wr_addr on the rising edge
//   wr_addr    write address
//   wr_data    write data
//   pop_addr   read address for the pop path
//   pop_data   combinational read data at pop_addr
//   peek_addr  read address for the top-of-stack peek
//   peek_data  combinational read data at peek_addr
module lifo_mem #(
  parameter int DEPTH      = 12,
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [ADDR_WIDTH-1:0] pop_addr,
  output logic [DATA_WIDTH-1:0] pop_data,
  input  logic [ADDR_WIDTH-1:0] peek_addr,
  output logic [DATA_WIDTH-1:0] peek_data
);

  // Storage is deliberately not reset; the stack controller never exposes
  // an entry that has not been written since the last reset or flush.
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign pop_data  = mem[pop_addr];
  assign peek_data = mem[peek_addr];

endmodule

// File: rtl/lifo_ext.sv
// rtl/lifo_ext.sv - LIFO stack with registered pop, peek, flush and sticky errors
//
// Ports:
//   clk            single clock, rising edge
//   rst            synchronous active-high reset
//   data_wr        push data
//   wr_en          push request
//   rd_en          pop request (wr_en and rd_en together = bypass)
//   flush          empty the stack and clear the sticky flags
//   data_rd        registered pop/bypass data
//   data_rd_valid  data_rd was updated by the previous cycle's request
//   top            combinational peek of the top entry, zero when empty
//   count          number of occupied entries
//   lifo_full      count == DEPTH
//   lifo_empty     count == 0
//   almost_full    count >= DEPTH-AF_MARGIN
//   almost_empty   count <= AE_MARGIN
//   overflow       sticky: a push was dropped while full
//   underflow      sticky: a pop was attempted while empty
module lifo_ext
  import lifo_pkg::*;
#(
  parameter int DEPTH      = LIFO_DEFAULT_DEPTH,
  parameter int DATA_WIDTH = LIFO_DEFAULT_DATA_WIDTH,
  parameter int AF_MARGIN  = LIFO_DEFAULT_AF_MARGIN,
  parameter int AE_MARGIN  = LIFO_DEFAULT_AE_MARGIN
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [DATA_WIDTH-1:0]              data_wr,
  input  logic                               wr_en,
  input  logic                               rd_en,
  input  logic                               flush,
  output logic [DATA_WIDTH-1:0]              data_rd,
  output logic                               data_rd_valid,
  output logic [DATA_WIDTH-1:0]              top,
  output logic [lifo_count_width(DEPTH)-1:0] count,
  output logic                               lifo_full,
  output logic                               lifo_empty,
  output logic                               almost_full,
  output logic                               almost_empty,
  output logic                               overflow,
  output logic                               underflow
);

  localparam int CW = lifo_count_width(DEPTH);
  localparam int AW = $clog2(DEPTH);

  // Parameter sanity: a one-entry stack and margins that swallow the whole
  // depth make the status flags meaningless.
  if (DEPTH < 2) begin : g_bad_depth
    $error("lifo_ext: DEPTH must be 2 or more");
  end
  if (AF_MARGIN >= DEPTH) begin : g_bad_af
    $error("lifo_ext: AF_MARGIN must be less than DEPTH");
  end
  if (AE_MARGIN >= DEPTH) begin : g_bad_ae
    $error("lifo_ext: AE_MARGIN must be less than DEPTH");
  end

  localparam logic [CW-1:0] FULL_LEVEL = CW'(DEPTH);
  localparam logic [CW-1:0] AF_LEVEL   = CW'(DEPTH - AF_MARGIN);
  localparam logic [CW-1:0] AE_LEVEL   = CW'(AE_MARGIN);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);

  // Status flags come from the registered count only, never from requests.
  assign lifo_full    = (count == FULL_LEVEL);
  assign lifo_empty   = (count == '0);
  assign almost_full  = (count >= AF_LEVEL);
  assign almost_empty = (count <= AE_LEVEL);

  // count is the next free slot; count-1 is the top entry. When empty the
  // wrapped address is never used because top is forced to zero and pops
  // are refused.
  logic [CW-1:0]         cnt_m1;
  logic [AW-1:0]         wr_addr;
  logic [AW-1:0]         top_addr;
  logic [DATA_WIDTH-1:0] pop_data;
  logic [DATA_WIDTH-1:0] peek_data;
  logic                  push_ok;

  assign cnt_m1   = count - CNT_ONE;
  assign wr_addr  = count[AW-1:0];
  assign top_addr = cnt_m1[AW-1:0];

  // Reset and flush both outrank a push, so the memory never sees a write
  // the counter does not account for.
  assign push_ok = !rst && !flush && wr_en && !rd_en && !lifo_full;

  lifo_mem #(
    .DEPTH      (DEPTH),
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (AW)
  ) u_mem (
    .clk       (clk),
    .wr_en     (push_ok),
    .wr_addr   (wr_addr),
    .wr_data   (data_wr),
    .pop_addr  (top_addr),
    .pop_data  (pop_data),
    .peek_addr (top_addr),
    .peek_data (peek_data)
  );

  assign top = lifo_empty ? '0 : peek_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      count         <= '0;
      data_rd       <= '0;
      data_rd_valid <= 1'b0;
      overflow      <= 1'b0;
      underflow     <= 1'b0;
    end else if (flush) begin
      // data_rd deliberately keeps its last value; only validity drops.
      count         <= '0;
      data_rd_valid <= 1'b0;
      overflow      <= 1'b0;
      underflow     <= 1'b0;
    end else begin
      unique case ({wr_en, rd_en})
        2'b11: begin
          // Bypass: the pushed word is handed straight back, stack untouched.
          data_rd       <= data_wr;
          data_rd_valid <= 1'b1;
        end
        2'b10: begin
          data_rd_valid <= 1'b0;
          if (lifo_full) begin
            overflow <= 1'b1;
          end else begin
            count <= count + CNT_ONE;
          end
        end
        2'b01: begin
          if (lifo_empty) begin
            underflow     <= 1'b1;
            data_rd_valid <= 1'b0;
          end else begin
            data_rd       <= pop_data;
            data_rd_valid <= 1'b1;
            count         <= cnt_m1;
          end
        end
        default: begin
          data_rd_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lifo_ext.sv
// tb/tb_lifo_ext.sv - directed vector table plus randomized queue-model check of lifo_ext
module tb_lifo_ext;

  localparam int DEPTH = 12;
  localparam int DW    = 8;
  localparam int AFM   = 2;
  localparam int AEM   = 2;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk;
  logic          rst;
  logic [DW-1:0] data_wr;
  logic          wr_en;
  logic          rd_en;
  logic          flush;
  logic [DW-1:0] data_rd;
  logic          data_rd_valid;
  logic [DW-1:0] top;
  logic [CW-1:0] count;
  logic          lifo_full;
  logic          lifo_empty;
  logic          almost_full;
  logic          almost_empty;
  logic          overflow;
  logic          underflow;

  lifo_ext #(
    .DEPTH      (DEPTH),
    .DATA_WIDTH (DW),
    .AF_MARGIN  (AFM),
    .AE_MARGIN  (AEM)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .data_wr       (data_wr),
    .wr_en         (wr_en),
    .rd_en         (rd_en),
    .flush         (flush),
    .data_rd       (data_rd),
    .data_rd_valid (data_rd_valid),
    .top           (top),
    .count         (count),
    .lifo_full     (lifo_full),
    .lifo_empty    (lifo_empty),
    .almost_full   (almost_full),
    .almost_empty  (almost_empty),
    .overflow      (overflow),
    .underflow     (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string         nm;
    logic          rst;
    logic          wr;
    logic          rd;
    logic          fl;
    logic [DW-1:0] d;
    int            cnt;
    logic [DW-1:0] drd;
    logic          vld;
    logic [DW-1:0] tp;
    logic          ovf;
    logic          unf;
  } vec_t;

  vec_t tbl[$];
  int   n_vec;
  int   n_cmp;
  int   n_fail;

  task automatic add(input string nm, input bit r, input bit w, input bit rd,
                     input bit f, input logic [DW-1:0] d, input int cnt,
                     input logic [DW-1:0] drd, input bit vld,
                     input logic [DW-1:0] tp, input bit ovf, input bit unf);
    vec_t v;
    v.nm = nm; v.rst = r; v.wr = w; v.rd = rd; v.fl = f; v.d = d;
    v.cnt = cnt; v.drd = drd; v.vld = vld; v.tp = tp; v.ovf = ovf; v.unf = unf;
    tbl.push_back(v);
  endtask

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (vector %0d): got %0h, expected %0h", nm, n_vec, act, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled 1 ns after the rising edge.
  task automatic drive(input bit r, input bit w, input bit rd, input bit f,
                       input logic [DW-1:0] d);
    @(negedge clk);
    rst = r; wr_en = w; rd_en = rd; flush = f; data_wr = d;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string nm, input int cnt, input logic [DW-1:0] drd,
                           input bit vld, input logic [DW-1:0] tp,
                           input bit ovf, input bit unf);
    n_vec++;
    cmp({nm, ".count"},        32'(count),         32'(cnt));
    cmp({nm, ".data_rd"},      32'(data_rd),       32'(drd));
    cmp({nm, ".valid"},        32'(data_rd_valid), 32'(vld));
    cmp({nm, ".top"},          32'(top),           32'(tp));
    cmp({nm, ".full"},         32'(lifo_full),     32'(cnt == DEPTH));
    cmp({nm, ".empty"},        32'(lifo_empty),    32'(cnt == 0));
    cmp({nm, ".almost_full"},  32'(almost_full),   32'(cnt >= DEPTH - AFM));
    cmp({nm, ".almost_empty"}, 32'(almost_empty),  32'(cnt <= AEM));
    cmp({nm, ".overflow"},     32'(overflow),      32'(ovf));
    cmp({nm, ".underflow"},    32'(underflow),     32'(unf));
  endtask

  // Behavioural reference: a plain queue as the stack.
  logic [DW-1:0] stk[$];
  logic [DW-1:0] m_drd;
  bit            m_vld;
  bit            m_ovf;
  bit            m_unf;

  task automatic model_step(input bit r, input bit w, input bit rd, input bit f,
                            input logic [DW-1:0] d);
    if (r) begin
      stk.delete(); m_drd = '0; m_vld = 0; m_ovf = 0; m_unf = 0;
    end else if (f) begin
      stk.delete(); m_vld = 0; m_ovf = 0; m_unf = 0;
    end else if (w && rd) begin
      m_drd = d; m_vld = 1;
    end else if (w) begin
      m_vld = 0;
      if (stk.size() == DEPTH) m_ovf = 1;
      else stk.push_back(d);
    end else if (rd) begin
      if (stk.size() == 0) begin
        m_unf = 1; m_vld = 0;
      end else begin
        m_drd = stk.pop_back(); m_vld = 1;
      end
    end else begin
      m_vld = 0;
    end
  endtask

  initial begin
    n_vec = 0; n_cmp = 0; n_fail = 0;
    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; flush = 1'b0; data_wr = '0;

    //   name         rst wr rd fl data     cnt  data_rd  vld  top    ovf unf
    add("reset",        1, 0, 0, 0, 8'h00,   0,  8'h00,   0,  8'h00,  0,  0);
    for (int i = 0; i < 12; i++)
      add("push_fill",  0, 1, 0, 0, 8'(8'h11 + i), i + 1, 8'h00, 0, 8'(8'h11 + i), 0, 0);
    add("push_full",    0, 1, 0, 0, 8'hFF,  12,  8'h00,   0,  8'h1C,  1,  0);
    for (int i = 0; i < 12; i++)
      add("pop_drain",  0, 0, 1, 0, 8'h00, 11 - i, 8'(8'h1C - i), 1,
          (i < 11) ? 8'(8'h1B - i) : 8'h00, 1, 0);
    add("pop_empty",    0, 0, 1, 0, 8'h00,   0,  8'h11,   0,  8'h00,  1,  1);
    add("bypass_empty", 0, 1, 1, 0, 8'hA5,   0,  8'hA5,   1,  8'h00,  1,  1);
    add("idle",         0, 0, 0, 0, 8'h00,   0,  8'hA5,   0,  8'h00,  1,  1);
    add("flush_clear",  0, 0, 0, 1, 8'h00,   0,  8'hA5,   0,  8'h00,  0,  0);
    add("peek_push1",   0, 1, 0, 0, 8'h42,   1,  8'hA5,   0,  8'h42,  0,  0);
    add("peek_push2",   0, 1, 0, 0, 8'h43,   2,  8'hA5,   0,  8'h43,  0,  0);
    add("peek_pop",     0, 0, 1, 0, 8'h00,   1,  8'h43,   1,  8'h42,  0,  0);
    add("drain_last",   0, 0, 1, 0, 8'h00,   0,  8'h42,   1,  8'h00,  0,  0);
    add("force_unf",    0, 0, 1, 0, 8'h00,   0,  8'h42,   0,  8'h00,  0,  1);
    for (int i = 0; i < 3; i++)
      add("push3",      0, 1, 0, 0, 8'(1 + i), i + 1, 8'h42, 0, 8'(1 + i), 0, 1);
    add("flush_wr",     0, 1, 0, 1, 8'h77,   0,  8'h42,   0,  8'h00,  0,  0);
    for (int i = 0; i < 5; i++)
      add("push5",      0, 1, 0, 0, 8'(8'h51 + i), i + 1, 8'h42, 0, 8'(8'h51 + i), 0, 0);
    add("pop5",         0, 0, 1, 0, 8'h00,   4,  8'h55,   1,  8'h54,  0,  0);
    add("rst_wr",       1, 1, 0, 0, 8'h99,   0,  8'h00,   0,  8'h00,  0,  0);
    add("post_rst",     0, 1, 0, 0, 8'h66,   1,  8'h00,   0,  8'h66,  0,  0);

    foreach (tbl[k]) begin
      drive(tbl[k].rst, tbl[k].wr, tbl[k].rd, tbl[k].fl, tbl[k].d);
      check_all(tbl[k].nm, tbl[k].cnt, tbl[k].drd, tbl[k].vld, tbl[k].tp,
                tbl[k].ovf, tbl[k].unf);
    end

    // Bypass while full: count and contents must stay put.
    drive(1, 0, 0, 0, 8'h00);
    model_step(1, 0, 0, 0, 8'h00);
    for (int i = 0; i < DEPTH; i++) begin
      drive(0, 1, 0, 0, 8'(8'hC0 + i));
      model_step(0, 1, 0, 0, 8'(8'hC0 + i));
    end
    drive(0, 1, 1, 0, 8'h3C);
    model_step(0, 1, 1, 0, 8'h3C);
    check_all("bypass_full", stk.size(), m_drd, m_vld,
              (stk.size() > 0) ? stk[$] : '0, m_ovf, m_unf);
    drive(0, 0, 1, 0, 8'h00);
    model_step(0, 0, 1, 0, 8'h00);
    check_all("pop_after_bypass", stk.size(), m_drd, m_vld,
              (stk.size() > 0) ? stk[$] : '0, m_ovf, m_unf);

    // Randomized run with alternating push-heavy / pop-heavy phases.
    for (int k = 0; k < 3000; k++) begin
      bit            r, w, rd, f;
      int            pw;
      logic [DW-1:0] d;
      pw = ((k / 150) % 2 == 0) ? 70 : 30;
      r  = ($urandom_range(0, 299) == 0);
      f  = ($urandom_range(0, 59) == 0);
      w  = ($urandom_range(0, 99) < pw);
      rd = ($urandom_range(0, 99) < (100 - pw));
      d  = 8'($urandom);
      drive(r, w, rd, f, d);
      model_step(r, w, rd, f, d);
      check_all("random", stk.size(), m_drd, m_vld,
                (stk.size() > 0) ? stk[$] : '0, m_ovf, m_unf);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
